mux_arb_n: RTL

Parametrised N-input, W-bit selector with a registered output stage and a valid/ready handshake on every channel. It replaces fixed 3:1 register-address selection in the pRISC datapath wherever producers can stall or compete. It sits between multiple producers, such as decode-stage destination candidates or writeback sources, and a single downstream consumer. Channel choice comes either from an explicit `sel` input or from an internal round-robin arbiter, selected at compile time.

---
 rtl/mux_arb_pkg.sv | 10 +
 rtl/mux_arb_n_rr_pick.sv | 25 ++
 rtl/mux_arb_n.sv | 64 ++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants and channel-index helpers for mux_arb_n.
package mux_arb_pkg;
  localparam int MUX_DEFAULT_WIDTH = 5;
  function automatic int sel_sat(input int sel, input int n);
    return (sel >= n - 1) ? n - 1 : sel;
  endfunction
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/mux_arb_n_rr_pick.sv
// rr_pick: combinational round-robin grant, first valid channel at or after i_ptr.
module rr_pick #(
  parameter int NUM_IN = 3,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_valid,
  input  logic [SEL_W-1:0]  i_ptr,
  output logic [SEL_W-1:0]  o_grant,
  output logic              o_any
);
  logic [2*NUM_IN-1:0] w_dbl;
  logic [NUM_IN-1:0]   w_rot;
  logic [SEL_W-1:0]    w_off;
  logic [SEL_W:0]      w_sum;
  // Rotate so bit 0 is the channel at i_ptr; lowest set bit is the winner's offset.
  assign w_dbl = {i_valid, i_valid} >> i_ptr;
  assign w_rot = w_dbl[NUM_IN-1:0];
  always_comb begin
    w_off = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) w_off = w_rot[k] ? SEL_W'(k) : w_off;
  end
  assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_grant = (w_sum >= (SEL_W+1)'(NUM_IN)) ? SEL_W'(w_sum - (SEL_W+1)'(NUM_IN)) : SEL_W'(w_sum);
  assign o_any   = |i_valid;
endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-input valid/ready selector with registered output; MUX_RR_EN selects round-robin over sel.
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter int WIDTH  = MUX_DEFAULT_WIDTH,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_idx,
  input  logic                    out_ready
);
  logic [SEL_W-1:0] w_g;
  logic             w_req;
  logic             w_can_load;
  logic             w_xfer;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_idx;
`ifdef MUX_RR_EN
  logic [SEL_W-1:0] r_ptr;
  logic             w_any;
  rr_pick #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_pick (
    .i_valid(in_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_g),
    .o_any  (w_any)
  );
  assign w_req = w_any;
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (w_xfer) r_ptr <= SEL_W'(rr_next(int'(w_g), NUM_IN));
  end
`else
  assign w_g   = SEL_W'(sel_sat(int'(sel), NUM_IN));
  assign w_req = in_valid[w_g];
`endif
  assign w_can_load = !r_valid || out_ready;
  assign in_ready   = (rst || !w_can_load) ? '0 : NUM_IN'(1) << w_g;
  assign w_xfer     = !rst && w_can_load && w_req;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= in_data[w_g*WIDTH +: WIDTH];
      r_idx   <= w_g;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
endmodule
